// File: rtl/muladd_seq.sv
// ============================================================================
// Module      : muladd_seq
// Description : Sequential radix-2 shift-add multiply-add, result = a*b + c.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module muladd_seq #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               sign,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic [WIDTH-1:0]   c,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] result
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] C_LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CALC   = 2'd1,
        FINISH = 2'd2
    } state_t;

    state_t               state_q,  state_d;
    logic [2*WIDTH-1:0]   mcand_q,  mcand_d;
    logic [WIDTH-1:0]     mplier_q, mplier_d;
    logic [2*WIDTH-1:0]   acc_q,    acc_d;
    logic [CW-1:0]        count_q,  count_d;
    logic                 neg_q,    neg_d;
    logic                 sign_q,   sign_d;
    logic [WIDTH-1:0]     c_q,      c_d;
    logic                 done_q,   done_d;
    logic [2*WIDTH-1:0]   result_q, result_d;

    logic [WIDTH-1:0]     mag_a;
    logic [WIDTH-1:0]     mag_b;
    logic [2*WIDTH-1:0]   product;
    logic [2*WIDTH-1:0]   c_ext;

    // Magnitudes are kept as unsigned W-bit values so -2^(W-1) maps to 2^(W-1).
    assign mag_a   = (sign && a[WIDTH-1]) ? (~a + 1'b1) : a;
    assign mag_b   = (sign && b[WIDTH-1]) ? (~b + 1'b1) : b;
    assign product = neg_q ? (~acc_q + 1'b1) : acc_q;
    assign c_ext   = sign_q ? {{WIDTH{c_q[WIDTH-1]}}, c_q} : {{WIDTH{1'b0}}, c_q};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            count_q  <= '0;
            neg_q    <= 1'b0;
            sign_q   <= 1'b0;
            c_q      <= '0;
            done_q   <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            count_q  <= count_d;
            neg_q    <= neg_d;
            sign_q   <= sign_d;
            c_q      <= c_d;
            done_q   <= done_d;
            result_q <= result_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        count_d  = count_q;
        neg_d    = neg_q;
        sign_d   = sign_q;
        c_d      = c_q;
        done_d   = 1'b0;
        result_d = result_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    sign_d   = sign;
                    c_d      = c;
                    neg_d    = sign & (a[WIDTH-1] ^ b[WIDTH-1]);
                    mcand_d  = {{WIDTH{1'b0}}, mag_a};
                    mplier_d = mag_b;
                    acc_d    = '0;
                    count_d  = '0;
                    state_d  = CALC;
                end
            end
            CALC: begin
                if (mplier_q[0]) begin
                    acc_d = acc_q + mcand_q;
                end
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                count_d  = count_q + 1'b1;
                if (count_q == C_LAST) begin
                    state_d = FINISH;
                end
            end
            FINISH: begin
                result_d = product + c_ext;
                done_d   = 1'b1;
                state_d  = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy   = (state_q != IDLE);
    assign done   = done_q;
    assign result = result_q;

endmodule

`default_nettype wire

// File: tb/tb_muladd_seq.sv
// ============================================================================
// Module      : tb_muladd_seq
// Description : Directed self-checking bench for muladd_seq (WIDTH = 8).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_muladd_seq;

    localparam int WIDTH = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        sign;
    logic [7:0]  a, b, c;
    logic        busy, done;
    logic [15:0] result;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    muladd_seq #(.WIDTH(WIDTH)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .sign   (sign),
        .a      (a),
        .b      (b),
        .c      (c),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference: plain integer arithmetic truncated to 16 bits.
    function automatic logic [15:0] ref_ma(input logic [7:0] x, input logic [7:0] y,
                                           input logic [7:0] z, input logic s);
        int xv, yv, zv;
        xv = s ? int'($signed(x)) : int'(x);
        yv = s ? int'($signed(y)) : int'(y);
        zv = s ? int'($signed(z)) : int'(z);
        return 16'(xv * yv + zv);
    endfunction

    // Called on the negedge right after the start edge; returns edges until done.
    task automatic wait_done(output int lat);
        lat = 0;
        while (!done && lat < 40) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic launch(input logic [7:0] ia, input logic [7:0] ib,
                          input logic [7:0] ic, input logic isg);
        @(negedge clk);
        a = ia; b = ib; c = ic; sign = isg; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a = 8'($urandom); b = 8'($urandom); c = 8'($urandom); sign = 1'($urandom);
    endtask

    task automatic do_op(input logic [7:0] ia, input logic [7:0] ib, input logic [7:0] ic,
                         input logic isg, input logic [15:0] exp, input string tag);
        int lat;
        launch(ia, ib, ic, isg);
        check({tag, "_busy"}, 32'(busy), 32'd1);
        wait_done(lat);
        check({tag, "_lat"}, 32'(lat), 32'd9);
        check({tag, "_res"}, 32'(result), 32'(exp));
        check({tag, "_busy_at_done"}, 32'(busy), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int lat;
        int seen;
        logic [7:0]  ra, rb, rc;
        logic        rs;
        logic [15:0] dvd;
        logic [7:0]  dvs, q, r;

        rst_n = 1'b0; start = 1'b0; sign = 1'b0; a = '0; b = '0; c = '0;
        repeat (2) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_result", 32'(result), 32'd0);
        rst_n = 1'b1;

        // Directed vectors with hand-computed results
        do_op(8'd6,   8'd7,   8'd0,   1'b1, 16'd42,   "recon_6x7");
        do_op(8'd3,   8'd37,  8'd16,  1'b1, 16'd127,  "recon_3x37p16");
        do_op(8'hFA,  8'd7,   8'd0,   1'b1, 16'hFFD6, "neg6x7");
        do_op(8'd0,   8'hD6,  8'd7,   1'b1, 16'd7,    "zero_x_neg42");
        do_op(8'h80,  8'h80,  8'd127, 1'b1, 16'h407F, "minneg_sq");
        do_op(8'hFF,  8'hFF,  8'hFF,  1'b0, 16'hFF00, "uns_max");
        do_op(8'hFF,  8'hFF,  8'hFF,  1'b1, 16'h0000, "sgn_m1");

        // start raised mid-CALC must be ignored
        launch(8'd5, 8'd5, 8'd3, 1'b0);
        @(negedge clk); @(negedge clk);
        a = 8'd100; b = 8'd100; c = 8'd1; sign = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(lat);
        check("midcalc_lat", 32'(lat + 3), 32'd9);
        check("midcalc_res", 32'(result), 32'h1C);
        @(negedge clk);
        check("midcalc_no_restart", 32'(busy), 32'd0);

        // start held across done: second op begins with no gap
        @(negedge clk);
        a = 8'd9; b = 8'd9; c = 8'd9; sign = 1'b0; start = 1'b1;
        @(negedge clk);
        wait_done(lat);
        check("b2b_lat1", 32'(lat), 32'd9);
        check("b2b_res1", 32'(result), 32'h5A);
        check("b2b_busy_at_done", 32'(busy), 32'd0);
        a = 8'd2; b = 8'hFD; c = 8'd1; sign = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("b2b_busy2", 32'(busy), 32'd1);
        check("b2b_done_low", 32'(done), 32'd0);
        wait_done(lat);
        check("b2b_lat2", 32'(lat), 32'd9);
        check("b2b_res2", 32'(result), 32'hFFFB);

        // Asynchronous reset at count 4 aborts the operation
        launch(8'd7, 8'd7, 8'd7, 1'b0);
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_done", 32'(done), 32'd0);
        check("arst_result", 32'(result), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (15) begin
            @(negedge clk);
            if (done) seen++;
        end
        check("arst_no_done", 32'(seen), 32'd0);
        do_op(8'd3, 8'd37, 8'd16, 1'b1, 16'd127, "post_rst");

        // Random operands against the integer reference
        for (int i = 0; i < 150; i++) begin
            ra = 8'($urandom); rb = 8'($urandom); rc = 8'($urandom); rs = 1'($urandom);
            launch(ra, rb, rc, rs);
            wait_done(lat);
            check("rand_res", 32'(result), 32'(ref_ma(ra, rb, rc, rs)));
        end

        // Divider reconstruction: q*divisor + r must give back the dividend
        for (int i = 0; i < 60; i++) begin
            dvs = 8'($urandom_range(1, 255));
            dvd = 16'($urandom_range(0, 256 * int'(dvs) - 1));
            q   = 8'(dvd / 16'(dvs));
            r   = 8'(dvd % 16'(dvs));
            launch(q, dvs, r, 1'b0);
            wait_done(lat);
            check("div_recon", 32'(result), 32'(dvd));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
